// File: rtl/list_drain.sv
// Consumer end of the 8-bit lazy-list stream: pulls elements one req edge at a time,
// buffers them, and reports count, signed sum and the reason the drain stopped.
module list_drain #(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 64
) (
  input  logic       clock,
  input  logic       ready,
  input  logic       start,
  output logic       list_req,
  input  logic       list_ack,
  input  logic [7:0] list_value,
  input  logic       list_value_valid,
  output logic       busy,
  output logic       done,
  output logic       truncated,
  output logic       timed_out,
  output logic [7:0] count,
  output logic [15:0] sum,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] CAP      = 8'(MAX_LEN);
  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, GAP, DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  tmo, tmo_next;
  logic [7:0]  count_next;
  logic [15:0] sum_next;
  logic        truncated_next, timed_out_next;
  logic        wr_en;

  logic [7:0]  mem [MAX_LEN];
  logic [7:0]  mem_q;
  logic        hit;

  always_comb begin
    state_next     = state;
    tmo_next       = tmo;
    count_next     = count;
    sum_next       = sum;
    truncated_next = truncated;
    timed_out_next = timed_out;
    wr_en          = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          count_next     = 8'd0;
          sum_next       = 16'd0;
          truncated_next = 1'b0;
          timed_out_next = 1'b0;
          state_next     = REQ;
        end
      end
      REQ: begin
        tmo_next   = TMO_LOAD;
        state_next = WAIT;
      end
      WAIT: begin
        if (list_ack) begin
          if (list_value_valid) begin
            wr_en      = 1'b1;
            count_next = count + 8'd1;
            sum_next   = sum + {{8{list_value[7]}}, list_value};
            if (count + 8'd1 == CAP) begin
              truncated_next = 1'b1;
              state_next     = DONE;
            end else begin
              state_next = GAP;
            end
          end else begin
            state_next = DONE;
          end
        end else begin
          // Counter was loaded with TIMEOUT, so hitting 1 here means TIMEOUT WAIT cycles elapsed
          tmo_next = tmo - 8'd1;
          if (tmo == 8'd1) begin
            timed_out_next = 1'b1;
            state_next     = DONE;
          end
        end
      end
      GAP:     state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge ready) begin
    if (!ready) begin
      state     <= IDLE;
      list_req  <= 1'b0;
      tmo       <= 8'd0;
      count     <= 8'd0;
      sum       <= 16'd0;
      truncated <= 1'b0;
      timed_out <= 1'b0;
      hit       <= 1'b0;
    end else begin
      state     <= state_next;
      // Registered from the current state: req rises as WAIT is entered and drops one edge after GAP
      list_req  <= (state == REQ) || (state == WAIT);
      tmo       <= tmo_next;
      count     <= count_next;
      sum       <= sum_next;
      truncated <= truncated_next;
      timed_out <= timed_out_next;
      hit       <= (rd_addr < count);
    end
  end

  // Buffer kept reset-free so it maps onto block RAM; stale words are masked by the hit flag
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[count[AW-1:0]] <= list_value;
    end
    mem_q <= mem[rd_addr[AW-1:0]];
  end

  assign rd_data = hit ? mem_q : 8'hFF;
  assign busy    = (state == REQ) || (state == WAIT) || (state == GAP);
  assign done    = (state == DONE);

endmodule
